// File: rtl/fpu16_pkg.sv
// fpu16_pkg
// Shared definitions for the binary16 floating-point unit: field widths,
// opcode encodings, the controller state enum and a small unpack helper.
// No ports; imported by fpu16 and fpu16_divider.
package fpu16_pkg;

    localparam int EXP_W   = 5;
    localparam int FRAC_W  = 10;
    localparam int BIAS    = 15;
    localparam int GUARD_W = 3;
    localparam int SIG_W   = FRAC_W + 1;       // hidden bit plus fraction
    localparam int MANT_W  = SIG_W + GUARD_W;  // significand plus guard bits
    localparam int QUO_W   = 12;               // quotient bits from the divider

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_ALIGN,
        ST_ADD,
        ST_MUL,
        ST_DIV,
        ST_NORM,
        ST_PACK,
        ST_DONE
    } state_t;

    // A zero exponent means zero (subnormals flush), otherwise prepend the
    // hidden one.
    function automatic logic [SIG_W-1:0] sigOf(input logic [14:0] f);
        return (f[14:10] == '0) ? '0 : {1'b1, f[9:0]};
    endfunction

endpackage

// File: rtl/fpu16_divider.sv
// fpu16_divider
// Iterative restoring divider for 11-bit significands, one quotient bit per
// clock. Produces floor(dividend * 2^11 / divisor) as a 12-bit quotient, so
// quotient bit 11 has weight 1.0.
// Ports: clk, reset (async, active-high), start (load operands), dividend,
// divisor, busy (high while iterating), quotient.
module fpu16_divider
    import fpu16_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SIG_W-1:0] dividend,
    input  logic [SIG_W-1:0] divisor,
    output logic             busy,
    output logic [QUO_W-1:0] quotient
);

    logic [SIG_W+1:0] r_rem;
    logic [SIG_W-1:0] r_divisor;
    logic [QUO_W-1:0] r_quo;
    logic [3:0]       r_count;
    logic             r_busy;
    logic             w_fits;
    logic [SIG_W:0]   w_trial;

    // The partial remainder never reaches 2^12, so a 12-bit trial
    // subtraction is exact whenever the divisor fits.
    assign w_fits  = r_rem >= {2'b00, r_divisor};
    assign w_trial = r_rem[SIG_W:0] - {1'b0, r_divisor};

    // Load on start, then shift in one quotient bit per cycle until the
    // count runs out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem     <= '0;
            r_divisor <= '0;
            r_quo     <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
        end else if (start) begin
            r_rem     <= {2'b00, dividend};
            r_divisor <= divisor;
            r_quo     <= '0;
            r_count   <= 4'(QUO_W);
            r_busy    <= 1'b1;
        end else if (r_busy) begin
            if (w_fits) begin
                r_rem <= {w_trial, 1'b0};
                r_quo <= {r_quo[QUO_W-2:0], 1'b1};
            end else begin
                r_rem <= {r_rem[SIG_W:0], 1'b0};
                r_quo <= {r_quo[QUO_W-2:0], 1'b0};
            end
            r_count <= r_count - 4'd1;
            if (r_count == 4'd1) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy     = r_busy;
    assign quotient = r_quo;

endmodule

// File: rtl/fpu16.sv
// fpu16
// Multi-cycle binary16 add/subtract/multiply/divide with truncation, plus a
// numeric comparison of the operands. Releasing reset starts an operation.
// Ports: clk, reset (async, active-high), X/Y operands, opcode
// (0 add, 1 sub, 2 mul, 3 div), result, OFUF ([1] overflow, [0] underflow),
// done (result valid until next reset), compResult ({X>Y, X==Y, X<Y}).
module fpu16
    import fpu16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] X,
    input  logic [15:0] Y,
    input  logic [1:0]  opcode,
    output logic [15:0] result,
    output logic [1:0]  OFUF,
    output logic        done,
    output logic [2:0]  compResult
);

    state_t              r_state, w_nextState;
    logic [1:0]          r_op;
    logic                r_xZero, r_yZero;
    logic [MANT_W-1:0]   r_aMant, r_bMant;
    logic                r_aSign, r_bSign, r_sign;
    logic [MANT_W:0]     r_mant;
    logic signed [7:0]   r_exp;
    logic [3:0]          r_cnt;
    logic [15:0]         r_result;
    logic [1:0]          r_ofuf;
    logic [2:0]          r_comp;

    logic [EXP_W-1:0]    w_xExp, w_yExp, w_expDiff;
    logic [SIG_W-1:0]    w_xSig, w_ySig;
    logic                w_xZero, w_yZero, w_ySignEff, w_addSub, w_xGeY, w_swap;
    logic [3:0]          w_shift;
    logic signed [7:0]   w_xExpS, w_yExpS, w_loadExp;
    logic [14:0]         w_xMag, w_yMag;
    logic signed [16:0]  w_xKey, w_yKey;
    logic [2*SIG_W-1:0]  w_product;
    logic [MANT_W:0]     w_prodTop, w_sum;
    logic                w_sumSign, w_opAddSub, w_divEarly, w_normExit;
    logic [15:0]         w_earlyResult, w_packed;
    logic [1:0]          w_earlyOfuf, w_packOfuf;
    logic                w_divStart, w_divBusy;
    logic [QUO_W-1:0]    w_quotient;

    // Operand unpacking from the live inputs; only consumed in LOAD.
    assign w_xExp     = X[14:10];
    assign w_yExp     = Y[14:10];
    assign w_xSig     = sigOf(X[14:0]);
    assign w_ySig     = sigOf(Y[14:0]);
    assign w_xZero    = (w_xExp == '0);
    assign w_yZero    = (w_yExp == '0);
    assign w_addSub   = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign w_ySignEff = Y[15] ^ (opcode == OP_SUB);
    assign w_xGeY     = w_xExp >= w_yExp;
    assign w_swap     = w_addSub && !w_xGeY;
    assign w_expDiff  = w_xGeY ? (w_xExp - w_yExp) : (w_yExp - w_xExp);
    assign w_shift    = (w_expDiff > 5'd14) ? 4'd14 : w_expDiff[3:0];
    assign w_xExpS    = $signed({3'b000, w_xExp});
    assign w_yExpS    = $signed({3'b000, w_yExp});

    // Sign-magnitude keys map both zeros to 0, so -0 compares equal to +0.
    assign w_xMag = w_xZero ? 15'd0 : X[14:0];
    assign w_yMag = w_yZero ? 15'd0 : Y[14:0];
    assign w_xKey = X[15] ? -$signed({2'b00, w_xMag}) : $signed({2'b00, w_xMag});
    assign w_yKey = Y[15] ? -$signed({2'b00, w_yMag}) : $signed({2'b00, w_yMag});

    // Result exponent before normalization, chosen by the operation.
    always_comb begin
        w_loadExp = w_xGeY ? w_xExpS : w_yExpS;
        case (opcode)
            OP_MUL:  w_loadExp = w_xExpS + w_yExpS - $signed(8'(BIAS));
            OP_DIV:  w_loadExp = w_xExpS - w_yExpS + $signed(8'(BIAS));
            default: w_loadExp = w_xGeY ? w_xExpS : w_yExpS;
        endcase
    end

    // The product is lined up so its bit 20 (weight 1.0) lands on mantissa
    // bit 13 and a carry into bit 21 lands on bit 14.
    assign w_product = {{SIG_W{1'b0}}, r_aMant[MANT_W-1:GUARD_W]} *
                       {{SIG_W{1'b0}}, r_bMant[MANT_W-1:GUARD_W]};
    assign w_prodTop = 15'(w_product >> 7);

    // Signed-magnitude add: equal signs add, otherwise the larger magnitude
    // keeps its sign.
    always_comb begin
        w_sum     = {1'b0, r_aMant} + {1'b0, r_bMant};
        w_sumSign = r_aSign;
        if (r_aSign != r_bSign) begin
            if (r_aMant >= r_bMant) begin
                w_sum = {1'b0, r_aMant - r_bMant};
            end else begin
                w_sum     = {1'b0, r_bMant - r_aMant};
                w_sumSign = r_bSign;
            end
        end
    end

    assign w_opAddSub = (r_op == OP_ADD) || (r_op == OP_SUB);
    assign w_divEarly = r_yZero || r_xZero || (r_exp < 8'sd0) || (r_exp > 8'sd31);
    // Multiply and divide need at most one normalizing shift.
    assign w_normExit = (r_mant == '0) || r_mant[MANT_W] || r_mant[MANT_W-1] || !w_opAddSub;

    // Divide shortcuts: divide by zero wins over a zero dividend, then the
    // exponent range check.
    always_comb begin
        w_earlyResult = {r_sign, 5'h1F, 10'd0};
        w_earlyOfuf   = 2'b10;
        if (r_yZero) begin
            w_earlyResult = {r_sign, 5'h1F, 10'd0};
            w_earlyOfuf   = 2'b10;
        end else if (r_xZero) begin
            w_earlyResult = {r_sign, 15'd0};
            w_earlyOfuf   = 2'b00;
        end else if (r_exp < 8'sd0) begin
            w_earlyResult = {r_sign, 15'd0};
            w_earlyOfuf   = 2'b01;
        end
    end

    // Final packing: guard bits are simply dropped, exponent range saturates.
    always_comb begin
        w_packed   = {r_sign, r_exp[4:0], r_mant[MANT_W-2:GUARD_W]};
        w_packOfuf = 2'b00;
        if (r_mant == '0) begin
            w_packed = {r_sign, 15'd0};
        end else if (r_exp >= 8'sd31) begin
            w_packed   = {r_sign, 5'h1F, 10'd0};
            w_packOfuf = 2'b10;
        end else if (r_exp <= 8'sd0) begin
            w_packed   = {r_sign, 15'd0};
            w_packOfuf = 2'b01;
        end
    end

    fpu16_divider u_divider (
        .clk      (clk),
        .reset    (reset),
        .start    (w_divStart),
        .dividend (w_xSig),
        .divisor  (w_ySig),
        .busy     (w_divBusy),
        .quotient (w_quotient)
    );

    // State register; reset parks the controller in LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_LOAD: begin
                if (opcode == OP_MUL)      w_nextState = ST_MUL;
                else if (opcode == OP_DIV) w_nextState = ST_DIV;
                else if (w_shift == 4'd0)  w_nextState = ST_ADD;
                else                       w_nextState = ST_ALIGN;
            end
            ST_ALIGN: if (r_cnt == 4'd1) w_nextState = ST_ADD;
            ST_ADD:   w_nextState = ST_NORM;
            ST_MUL:   w_nextState = ST_NORM;
            ST_DIV: begin
                if (w_divEarly)      w_nextState = ST_DONE;
                else if (!w_divBusy) w_nextState = ST_NORM;
            end
            ST_NORM:  if (w_normExit) w_nextState = ST_PACK;
            ST_PACK:  w_nextState = ST_DONE;
            default:  w_nextState = ST_DONE;
        endcase
    end

    // Control outputs decoded from the state; the divider is launched in the
    // same cycle LOAD samples the operands.
    always_comb begin
        done       = (r_state == ST_DONE);
        w_divStart = (r_state == ST_LOAD) && (opcode == OP_DIV);
    end

    // Datapath: each state performs its one step on the working registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_xZero  <= 1'b0;
            r_yZero  <= 1'b0;
            r_aMant  <= '0;
            r_bMant  <= '0;
            r_aSign  <= 1'b0;
            r_bSign  <= 1'b0;
            r_sign   <= 1'b0;
            r_mant   <= '0;
            r_exp    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_ofuf   <= '0;
            r_comp   <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_op    <= opcode;
                    r_xZero <= w_xZero;
                    r_yZero <= w_yZero;
                    r_aMant <= {(w_swap ? w_ySig : w_xSig), {GUARD_W{1'b0}}};
                    r_bMant <= {(w_swap ? w_xSig : w_ySig), {GUARD_W{1'b0}}};
                    r_aSign <= w_swap ? w_ySignEff : X[15];
                    r_bSign <= w_swap ? X[15] : w_ySignEff;
                    r_sign  <= X[15] ^ Y[15];
                    r_exp   <= w_loadExp;
                    r_cnt   <= w_shift;
                    r_comp  <= {w_xKey > w_yKey, w_xKey == w_yKey, w_xKey < w_yKey};
                end
                ST_ALIGN: begin
                    r_bMant <= r_bMant >> 1;
                    r_cnt   <= r_cnt - 4'd1;
                end
                ST_ADD: begin
                    r_mant <= w_sum;
                    r_sign <= w_sumSign;
                end
                ST_MUL: r_mant <= w_prodTop;
                ST_DIV: begin
                    if (w_divEarly) begin
                        r_result <= w_earlyResult;
                        r_ofuf   <= w_earlyOfuf;
                    end else if (!w_divBusy) begin
                        r_mant <= {1'b0, w_quotient, 2'b00};
                    end
                end
                ST_NORM: begin
                    if (r_mant == '0) begin
                        if (w_opAddSub) r_sign <= 1'b0;
                    end else if (r_mant[MANT_W]) begin
                        r_mant <= r_mant >> 1;
                        r_exp  <= r_exp + 8'sd1;
                    end else if (!r_mant[MANT_W-1]) begin
                        r_mant <= r_mant << 1;
                        r_exp  <= r_exp - 8'sd1;
                    end
                end
                ST_PACK: begin
                    r_result <= w_packed;
                    r_ofuf   <= w_packOfuf;
                end
                default: ;
            endcase
        end
    end

    assign result     = r_result;
    assign OFUF       = r_ofuf;
    assign compResult = r_comp;

endmodule

// File: tb/tb_fpu16.sv
// tb_fpu16
// Directed-vector bench for fpu16: each vector resets the unit, releases
// reset, scrambles the inputs after the LOAD edge and checks result, flags,
// comparison and latency against hand-computed values.
module tb_fpu16;

    logic        clk;
    logic        reset;
    logic [15:0] X, Y;
    logic [1:0]  opcode;
    logic [15:0] result;
    logic [1:0]  OFUF;
    logic        done;
    logic [2:0]  compResult;

    int vectorCount = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  op;
        logic [15:0] res;
        logic [1:0]  ofuf;
        logic [2:0]  comp;
        int          maxLat;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    fpu16 dut (
        .clk        (clk),
        .reset      (reset),
        .X          (X),
        .Y          (Y),
        .opcode     (opcode),
        .result     (result),
        .OFUF       (OFUF),
        .done       (done),
        .compResult (compResult)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
        end
    endtask

    // Pulse reset with the operands applied, release it, scramble the inputs
    // after the LOAD edge and wait (bounded) for done.
    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y,
                                 input logic [1:0] op, output int lat);
        @(negedge clk);
        reset  = 1'b1;
        X      = x;
        Y      = y;
        opcode = op;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        lat    = 1;
        X      = 16'($urandom);
        Y      = 16'($urandom);
        opcode = 2'($urandom);
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Main sequence: reset values, the vector table, then async reset cases.
    initial begin
        int lat;
        reset  = 1'b1;
        X      = '0;
        Y      = '0;
        opcode = '0;

        vecs[0]  = '{16'h0F00, 16'h0B80, 2'd0, 16'h1160, 2'b00, 3'b100, 9};
        vecs[1]  = '{16'hD98D, 16'h4F08, 2'd0, 16'hD8AC, 2'b00, 3'b001, 9};
        vecs[2]  = '{16'hD98D, 16'h4F08, 2'd1, 16'hDA6E, 2'b00, 3'b001, 9};
        vecs[3]  = '{16'h118D, 16'hEF08, 2'd1, 16'h6F08, 2'b00, 3'b100, 20};
        vecs[4]  = '{16'h418D, 16'hB308, 2'd1, 16'h41FD, 2'b00, 3'b100, 9};
        vecs[5]  = '{16'h4F00, 16'h0B80, 2'd2, 16'h1E90, 2'b00, 3'b100, 4};
        vecs[6]  = '{16'hD98D, 16'h4F08, 2'd2, 16'hECE0, 2'b00, 3'b001, 4};
        vecs[7]  = '{16'h50BB, 16'h50BB, 2'd2, 16'h6598, 2'b00, 3'b010, 4};
        vecs[8]  = '{16'hD98D, 16'h4F08, 2'd3, 16'hC650, 2'b00, 3'b001, 16};
        vecs[9]  = '{16'h418D, 16'hB308, 2'd3, 16'hCA50, 2'b00, 3'b100, 16};
        vecs[10] = '{16'h118D, 16'hEF08, 2'd3, 16'h8000, 2'b01, 3'b100, 4};
        vecs[11] = '{16'h3C00, 16'h0000, 2'd3, 16'h7C00, 2'b10, 3'b100, 4};
        vecs[12] = '{16'hBC00, 16'h0000, 2'd2, 16'h8000, 2'b00, 3'b001, 4};
        vecs[13] = '{16'h3C00, 16'hBC00, 2'd0, 16'h0000, 2'b00, 3'b100, 9};
        vecs[14] = '{16'h7800, 16'h7800, 2'd2, 16'h7C00, 2'b10, 3'b010, 4};
        vecs[15] = '{16'h0400, 16'h0400, 2'd2, 16'h0000, 2'b01, 3'b010, 4};
        vecs[16] = '{16'h3C01, 16'h3C00, 2'd1, 16'h1400, 2'b00, 3'b100, 20};
        vecs[17] = '{16'h8000, 16'h0000, 2'd0, 16'h0000, 2'b00, 3'b010, 9};
        vecs[18] = '{16'h7800, 16'h0400, 2'd3, 16'h7C00, 2'b10, 3'b100, 4};

        #2;
        checkOutput("rst_result", result, 16'h0000);
        checkOutput("rst_ofuf", 16'(OFUF), 16'h0000);
        checkOutput("rst_done", 16'(done), 16'h0000);
        checkOutput("rst_comp", 16'(compResult), 16'h0000);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].op, lat);
            checkOutput($sformatf("v%0d_done", i), 16'(done), 16'h0001);
            checkOutput($sformatf("v%0d_result", i), result, vecs[i].res);
            checkOutput($sformatf("v%0d_ofuf", i), 16'(OFUF), 16'(vecs[i].ofuf));
            checkOutput($sformatf("v%0d_comp", i), 16'(compResult), 16'(vecs[i].comp));
            checkOutput($sformatf("v%0d_latOk", i), 16'(lat <= vecs[i].maxLat), 16'h0001);
        end

        // Multiply latency is fixed.
        applyStimulus(16'h4F00, 16'h0B80, 2'd2, lat);
        checkOutput("mul_latency", 16'(lat), 16'd4);

        // Completed divide, then reset asserted between clock edges.
        applyStimulus(16'hD98D, 16'h4F08, 2'd3, lat);
        checkOutput("div_before_rst", result, 16'hC650);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_result", result, 16'h0000);
        checkOutput("async_rst_done", 16'(done), 16'h0000);
        checkOutput("async_rst_comp", 16'(compResult), 16'h0000);

        // Abort a divide in flight.
        X      = 16'hD98D;
        Y      = 16'h4F08;
        opcode = 2'd3;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("middiv_done", 16'(done), 16'h0000);
        checkOutput("middiv_comp", 16'(compResult), 16'h0000);
        checkOutput("middiv_result", result, 16'h0000);

        // A fresh operation after the abort still completes correctly.
        applyStimulus(16'h418D, 16'hB308, 2'd3, lat);
        checkOutput("restart_result", result, 16'hCA50);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end

endmodule
